tokens_credit_tx: RTL and testbench

//   Credit-based transmitter feeding a remote tokens_sfifo over a link with no backpressure.

---
 rtl/tokens_credit_tx.sv | 114 +++++++++++
 tb/tb_tokens_credit_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tokens_credit_tx.sv
// Credit-based transmitter: forwards local valid/ready words to a remote FIFO over a
// registered, backpressure-free link, spending one credit per word and reclaiming one per remote pop.
module tokens_credit_tx #(
  parameter int DW       = 32,
  parameter int CREDITS  = 8,
  parameter bit MSKO     = 1'b0,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_vld,
  output logic          src_rdy,
  input  logic [DW-1:0] src_dat,
  output logic          link_vld,
  output logic [DW-1:0] link_dat,
  input  logic          crd_rtn,
  output logic [CW-1:0] crd_cnt,
  input  logic          drain_req,
  output logic          drain_ack,
  output logic          crd_err
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } state_t;

  localparam logic [CW:0]   FULL_W = (CW + 1)'(CREDITS);
  localparam logic [CW-1:0] FULL   = CW'(CREDITS);

  state_t        state_q, state_d;
  logic          link_vld_q, link_vld_d;
  logic [DW-1:0] link_dat_q, link_dat_d;
  logic [CW-1:0] crd_cnt_q, crd_cnt_d;
  logic          drain_ack_q, drain_ack_d;
  logic          crd_err_q, crd_err_d;
  logic          wen;
  logic [CW:0]   cnt_sum;

  // Ready must not look at src_vld, so upstream may wait on it without a loop.
  assign src_rdy = (state_q == RUN) & ~drain_req & (crd_cnt_q != '0);
  assign wen     = src_vld & src_rdy;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    link_vld_d  = wen;
    link_dat_d  = link_dat_q;
    crd_cnt_d   = crd_cnt_q;
    crd_err_d   = crd_err_q;
    drain_ack_d = 1'b0;

    if (wen) begin
      link_dat_d = src_dat;
    end else if (MSKO) begin
      link_dat_d = '0;
    end

    // One extra bit lets a return at the full count be seen as overflow rather than wrapping.
    cnt_sum = {1'b0, crd_cnt_q} - (CW + 1)'(wen) + (CW + 1)'(crd_rtn);
    if (cnt_sum > FULL_W) begin
      crd_cnt_d = FULL;
      crd_err_d = 1'b1;
    end else begin
      crd_cnt_d = cnt_sum[CW-1:0];
    end

    unique case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (!drain_req) begin
          state_d = RUN;
        end else if ((crd_cnt_q == FULL) && !link_vld_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!drain_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    drain_ack_d = (state_d == IDLE);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      link_vld_q  <= 1'b0;
      link_dat_q  <= '0;
      crd_cnt_q   <= FULL;
      drain_ack_q <= 1'b0;
      crd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      link_vld_q  <= link_vld_d;
      link_dat_q  <= link_dat_d;
      crd_cnt_q   <= crd_cnt_d;
      drain_ack_q <= drain_ack_d;
      crd_err_q   <= crd_err_d;
    end
  end

  assign link_vld  = link_vld_q;
  assign link_dat  = link_dat_q;
  assign crd_cnt   = crd_cnt_q;
  assign drain_ack = drain_ack_q;
  assign crd_err   = crd_err_q;

endmodule

// File: tb/tb_tokens_credit_tx.sv
// Directed bench for tokens_credit_tx with CREDITS=4: credit exhaustion, return, overflow,
// drain handshake and asynchronous reset mid-burst, each step checked against hand-computed values.
module tb_tokens_credit_tx;

  localparam int DW      = 32;
  localparam int CREDITS = 4;
  localparam int CW      = $clog2(CREDITS + 1);

  logic          clk;
  logic          rst_n;
  logic          src_vld;
  logic          src_rdy;
  logic [DW-1:0] src_dat;
  logic          link_vld;
  logic [DW-1:0] link_dat;
  logic          crd_rtn;
  logic [CW-1:0] crd_cnt;
  logic          drain_req;
  logic          drain_ack;
  logic          crd_err;

  int checks = 0;
  int errors = 0;

  tokens_credit_tx #(
    .DW      (DW),
    .CREDITS (CREDITS),
    .MSKO    (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_vld   (src_vld),
    .src_rdy   (src_rdy),
    .src_dat   (src_dat),
    .link_vld  (link_vld),
    .link_dat  (link_dat),
    .crd_rtn   (crd_rtn),
    .crd_cnt   (crd_cnt),
    .drain_req (drain_req),
    .drain_ack (drain_ack),
    .crd_err   (crd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational src_rdy settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    src_vld   = 1'b0;
    src_dat   = '0;
    crd_rtn   = 1'b0;
    drain_req = 1'b0;
    #12;
    check("rst link_vld", 32'(link_vld), 32'd0);
    check("rst link_dat", link_dat, 32'd0);
    check("rst crd_cnt", 32'(crd_cnt), 32'd4);
    check("rst drain_ack", 32'(drain_ack), 32'd0);
    check("rst crd_err", 32'(crd_err), 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    check("rst src_rdy", 32'(src_rdy), 32'd1);

    // 1: burst until credits run out
    src_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_dat = 32'hA0 + 32'(i);
      tick();
      check("t1 link_vld", 32'(link_vld), 32'd1);
      check("t1 link_dat", link_dat, 32'hA0 + 32'(i));
      check("t1 crd_cnt", 32'(crd_cnt), 32'(3 - i));
    end
    src_dat = 32'hA4;
    settle();
    check("t1 src_rdy empty", 32'(src_rdy), 32'd0);
    tick();
    check("t1 link_vld stall", 32'(link_vld), 32'd0);
    check("t1 link_dat hold", link_dat, 32'hA3);
    check("t1 crd_cnt zero", 32'(crd_cnt), 32'd0);

    // 2: single credit return releases exactly one word
    crd_rtn = 1'b1;
    tick();
    crd_rtn = 1'b0;
    check("t2 crd_cnt one", 32'(crd_cnt), 32'd1);
    check("t2 link_vld none", 32'(link_vld), 32'd0);
    settle();
    check("t2 src_rdy", 32'(src_rdy), 32'd1);
    tick();
    check("t2 link_vld", 32'(link_vld), 32'd1);
    check("t2 link_dat", link_dat, 32'hA4);
    check("t2 crd_cnt back", 32'(crd_cnt), 32'd0);
    tick();
    check("t2 link_vld after", 32'(link_vld), 32'd0);
    check("t2 crd_cnt stays", 32'(crd_cnt), 32'd0);
    src_vld = 1'b0;

    // 3: simultaneous send and return keep the count steady
    crd_rtn = 1'b1;
    tick();
    tick();
    check("t3 crd_cnt two", 32'(crd_cnt), 32'd2);
    src_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src_dat = 32'hB0 + 32'(i);
      tick();
      check("t3 link_vld", 32'(link_vld), 32'd1);
      check("t3 link_dat", link_dat, 32'hB0 + 32'(i));
      check("t3 crd_cnt", 32'(crd_cnt), 32'd2);
    end
    src_vld = 1'b0;
    crd_rtn = 1'b0;

    // 4: return at full count saturates and sets the sticky error
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t4 crd_cnt full", 32'(crd_cnt), 32'd4);
    crd_rtn = 1'b1;
    tick();
    crd_rtn = 1'b0;
    check("t4 crd_err set", 32'(crd_err), 32'd1);
    check("t4 crd_cnt sat", 32'(crd_cnt), 32'd4);
    tick();
    tick();
    check("t4 crd_err sticky", 32'(crd_err), 32'd1);

    // 5: drain with three words outstanding
    src_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_dat = 32'hC0 + 32'(i);
      tick();
    end
    check("t5 crd_cnt sent", 32'(crd_cnt), 32'd1);
    check("t5 link_vld last", 32'(link_vld), 32'd1);
    drain_req = 1'b1;
    settle();
    check("t5 src_rdy blocked", 32'(src_rdy), 32'd0);
    tick();
    check("t5 link_vld quiet", 32'(link_vld), 32'd0);
    check("t5 ack low", 32'(drain_ack), 32'd0);
    crd_rtn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5 crd_cnt return", 32'(crd_cnt), 32'(2 + i));
      check("t5 ack wait", 32'(drain_ack), 32'd0);
    end
    crd_rtn = 1'b0;
    tick();
    check("t5 ack high", 32'(drain_ack), 32'd1);
    check("t5 src_rdy idle", 32'(src_rdy), 32'd0);
    check("t5 crd_err kept", 32'(crd_err), 32'd1);
    src_vld   = 1'b0;
    drain_req = 1'b0;
    settle();
    check("t5 src_rdy still idle", 32'(src_rdy), 32'd0);
    tick();
    check("t5 ack drop", 32'(drain_ack), 32'd0);
    check("t5 src_rdy resume", 32'(src_rdy), 32'd1);

    // 6: asynchronous reset mid-burst
    src_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_dat = 32'hD0 + 32'(i);
      tick();
    end
    check("t6 crd_cnt pre", 32'(crd_cnt), 32'd1);
    check("t6 link_vld pre", 32'(link_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 link_vld rst", 32'(link_vld), 32'd0);
    check("t6 link_dat rst", link_dat, 32'd0);
    check("t6 crd_cnt rst", 32'(crd_cnt), 32'd4);
    check("t6 crd_err rst", 32'(crd_err), 32'd0);
    tick();
    rst_n   = 1'b1;
    src_dat = 32'hE0;
    tick();
    check("t6 resume vld", 32'(link_vld), 32'd1);
    check("t6 resume dat", link_dat, 32'hE0);
    check("t6 resume cnt", 32'(crd_cnt), 32'd3);
    src_vld = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
